rr_arb_8: RTL
=============

RR_ARB_8 -- requirements
Module: rr_arb_8

Interface
REQ-001 Parameter: HOLD_MAX, default 16, maximum grant tenure in cycles (timeout build only, legal range 2..255).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk only.
REQ-004 req  input  8  request vector, bit i = requester i, level-sensitive.
REQ-005 done  input  1  owner releases the resource; meaningful only while gnt_valid=1.
REQ-006 gnt  output  8  registered one-hot grant, all-zero when idle.
REQ-007 gnt_id  output  3  registered binary index of the current owner; 0 when idle.
REQ-008 gnt_valid  output  1  registered, high while a grant is held.
REQ-009 timeout  output  1  one-cycle pulse on forced revocation; constant 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-010 FSM states SHALL be IDLE and GRANT only; illegal encodings SHALL return to IDLE on the next edge.
REQ-011 IDLE with req==0: stay in IDLE, outputs hold their idle values.
REQ-012 IDLE with req!=0: select the first set bit searching upward from ptr modulo 8; gnt, gnt_id and gnt_valid SHALL assert on the next edge (1-cycle latency) and the FSM SHALL enter GRANT.
REQ-013 gnt SHALL always equal the 3-to-8 one-hot decode of gnt_id while gnt_valid=1, and SHALL be 8'h00 otherwise.
REQ-014 GRANT: grant held unchanged while req[gnt_id]=1 and done=0; changes on other req bits SHALL be ignored.
REQ-015 GRANT release: done=1 or req[gnt_id]=0 -> next edge: gnt=0, gnt_valid=0, gnt_id=0, ptr=(old gnt_id+1) mod 8 (wraps 7->0), FSM to IDLE.
REQ-016 One idle (dead) cycle SHALL separate consecutive grants; back-to-back grant without it is forbidden.
REQ-017 done asserted in IDLE SHALL be ignored.
REQ-018 done and timeout expiry in the same cycle: treat as normal release; timeout SHALL NOT pulse.
REQ-019 Fairness: with all 8 bits continuously requesting and each owner releasing, grants SHALL visit 0..7 in order, repeating.

Reset
REQ-020 rst=1 at an edge: state=IDLE, gnt=8'h00, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, tenure counter=0; overrides every other input.
REQ-021 rst asserted mid-GRANT SHALL drop the grant on that same edge, without a timeout pulse.
REQ-022 First grant after reset SHALL search from index 0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: an 8-bit tenure counter clears on entry to GRANT and increments each GRANT cycle; when it reaches HOLD_MAX-1 without a release, the next edge SHALL revoke as in REQ-015, with timeout=1 for that one cycle.
REQ-024 ARB_TIMEOUT_EN undefined: no counter logic; a grant is held indefinitely until release; timeout tied to 0.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (IDLE=1'b0, GRANT=1'b1), the requester count 8, and the index width 3.
REQ-026 One sub-module, onehot_dec3, SHALL perform the gnt_id-to-gnt 3-to-8 decode, gated by gnt_valid.
REQ-027 The round-robin priority search SHALL be combinational inside rr_arb_8; all outputs SHALL be registered.

Verification
REQ-028 Reset, then req=8'h00 for 5 cycles -> gnt=8'h00, gnt_valid=0 throughout.
REQ-029 req=8'h24 from reset -> after 1 cycle gnt=8'h04, gnt_id=2; done pulse -> idle cycle -> gnt=8'h20, gnt_id=5.
REQ-030 req=8'hFF held, done pulsed 2 cycles after each grant -> gnt_id sequence 0,1,...,7,0 with a dead cycle between grants.
REQ-031 Owner 3 holds, req[3] drops with done=0 -> gnt=0 on the next edge; ptr=4, so with req=8'h18 the next grant is 8'h10.
REQ-032 ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h01 held, done=0 -> grant for 4 cycles, then timeout=1 for one cycle, gnt=0, then re-grant 8'h01 after the idle cycle.
REQ-033 rst pulsed while gnt=8'h40 -> gnt=0 and timeout=0 on that edge; the next grant with req=8'hC0 is 8'h40 because ptr=0.

Source files
------------

// File: rtl/rr_arb_8_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter: FSM encoding,
// requester count and index width.
package rr_arb_8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb_8_onehot_dec3.sv
// 3-to-8 one-hot decode of the owner index, forced to zero when no grant is held.
module onehot_dec3
  import rr_arb_8_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb_8.sv
// Round-robin arbiter for 8 requesters with a mandatory dead cycle between grants.
// Optional forced revocation after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
//
//   state | meaning
//   IDLE  | no owner; search upward from ptr for the next requester
//   GRANT | owner gnt_id holds the resource until done, req drop or timeout
module rr_arb_8
  import rr_arb_8_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range_chk
    $error("rr_arb_8: HOLD_MAX must be within 2..255");
  end

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] gnt_id_nxt;
  logic             valid_nxt;
  logic [IDX_W-1:0] sel_id;
  logic [IDX_W-1:0] cand;
  logic             sel_found;
  logic             release_own;
  logic             expire;

  // First requester at or above ptr, wrapping modulo 8.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign release_own = done || !req[gnt_id];

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    gnt_id_nxt = gnt_id;
    valid_nxt  = gnt_valid;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt  = GRANT;
          gnt_id_nxt = sel_id;
          valid_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (release_own || expire) begin
          state_nxt  = IDLE;
          gnt_id_nxt = '0;
          valid_nxt  = 1'b0;
          ptr_nxt    = gnt_id + IDX_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        gnt_id_nxt = '0;
        valid_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= valid_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tenure;

  assign expire = (state == GRANT) && (tenure == 8'(HOLD_MAX - 1));

  // A release in the expiry cycle wins: no timeout pulse in that case.
  always_ff @(posedge clk) begin
    if (rst) begin
      tenure  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire && !release_own;
      if (state == GRANT && !release_own && !expire)
        tenure <= tenure + 8'd1;
      else
        tenure <= '0;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  onehot_dec3 u_dec (
    .idx    (gnt_id),
    .en     (gnt_valid),
    .onehot (gnt)
  );

endmodule
